// File: rtl/data_memory_ctrl.sv
// Data memory for the load/store path: sized stores with byte lanes, extended loads,
// request/response handshake with LATENCY wait states and error responses.
module data_memory_ctrl #(
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] a_i,
  input  logic [31:0] wd_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rd_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] a_q, wd_q;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;
  logic        commit;

  logic [31:0] mem_q [DEPTH] = '{default: '0};

  // With LATENCY=0 the commit happens on the accepting edge, so use the live inputs in IDLE.
  logic        op_we, op_uns;
  logic [1:0]  op_size;
  logic [31:0] op_a, op_wd;
  logic        op_err;
  logic [AW-1:0] idx;
  logic [31:0] rdata, wdata, ext;
  logic [3:0]  be;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    if (state_q == StIdle) begin
      op_we   = we_i;
      op_uns  = uns_i;
      op_size = size_i;
      op_a    = a_i;
      op_wd   = wd_i;
    end else begin
      op_we   = we_q;
      op_uns  = uns_q;
      op_size = size_q;
      op_a    = a_q;
      op_wd   = wd_q;
    end
  end

  assign op_err = (op_size == 2'b11) ||
                  ((op_size == 2'b01) && op_a[0]) ||
                  ((op_size == 2'b10) && (op_a[1:0] != 2'b00)) ||
                  ({2'b00, op_a[31:2]} >= 32'(DEPTH));
  assign idx      = op_a[AW+1:2];
  assign rdata    = mem_q[idx];
  assign byte_sel = 8'(rdata >> {op_a[1:0], 3'b000});
  assign half_sel = 16'(rdata >> {op_a[1], 4'b0000});

  always_comb begin
    be    = 4'b1111;
    wdata = op_wd;
    ext   = rdata;
    unique case (op_size)
      2'b00: begin
        be    = 4'b0001 << op_a[1:0];
        wdata = {4{op_wd[7:0]}};
        ext   = {{24{~op_uns & byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        be    = op_a[1] ? 4'b1100 : 4'b0011;
        wdata = {2{op_wd[15:0]}};
        ext   = {{16{~op_uns & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          if (LATENCY == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) begin
          state_d = StResp;
          commit  = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_d  = rd_q;
    err_d = err_q;
    if (commit) begin
      err_d = op_err;
      rd_d  = (op_we || op_err) ? 32'd0 : ext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      a_q     <= 32'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      if ((state_q == StIdle) && req_i) begin
        we_q   <= we_i;
        uns_q  <= uns_i;
        size_q <= size_i;
        a_q    <= a_i;
        wd_q   <= wd_i;
      end
    end
  end

  // The array is never reset; gating on rst_ni keeps an in-reset request from writing.
  always_ff @(posedge clk_i) begin
    if (rst_ni && commit && op_we && !op_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign rvalid_o = (state_q == StResp);
  assign rd_o     = rd_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: instance 0 has LATENCY=2, instance 1 has LATENCY=0.
module tb_data_memory_ctrl;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          we;
    bit [1:0]    sz;
    bit          uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
  } op_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req, we, uns, ready, rvalid, err;
  logic [1:0][1:0]  size;
  logic [1:0][31:0] a, wd, rd;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_memory_ctrl #(.DEPTH(2048), .LATENCY(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
    .uns_i(uns[0]), .a_i(a[0]), .wd_i(wd[0]), .ready_o(ready[0]), .rvalid_o(rvalid[0]),
    .rd_o(rd[0]), .err_o(err[0])
  );

  data_memory_ctrl #(.DEPTH(2048), .LATENCY(0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
    .uns_i(uns[1]), .a_i(a[1]), .wd_i(wd[1]), .ready_o(ready[1]), .rvalid_o(rvalid[1]),
    .rd_o(rd[1]), .err_o(err[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int d, input logic [31:0] r, input logic e, input int c);
    exp_t x;
    x.rd  = r;
    x.err = e;
    x.cyc = c;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst_n) begin
      if (rvalid[0]) begin
        check_eq("rvalid0_excl_ready", 32'(ready[0]), 32'd0);
        if (q0.size() == 0) check_eq("spurious_rvalid0", 32'd1, 32'd0);
        else begin
          x = q0.pop_front();
          check_eq("rd0", rd[0], x.rd);
          check_eq("err0", 32'(err[0]), 32'(x.err));
          check_eq("rvalid0_cycle", cyc, x.cyc);
        end
      end
      if (rvalid[1]) begin
        if (q1.size() == 0) check_eq("spurious_rvalid1", 32'd1, 32'd0);
        else begin
          x = q1.pop_front();
          check_eq("rd1", rd[1], x.rd);
          check_eq("err1", 32'(err[1]), 32'(x.err));
          check_eq("rvalid1_cycle", cyc, x.cyc);
        end
      end
    end
  end

  task automatic wait_ready(input int d);
    int t = 0;
    while (!ready[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready[d]) check_eq("ready_timeout", 32'(ready[d]), 32'd1);
  endtask

  task automatic drive(input int d, input op_t o);
    we[d]   = o.we;
    size[d] = o.sz;
    uns[d]  = o.uns;
    a[d]    = o.a;
    wd[d]   = o.wd;
    req[d]  = 1'b1;
    push(d, o.rd, o.err, cyc + 1 + lat(d));
  endtask

  task automatic drain(input int d);
    int t = 0;
    while (qsize(d) != 0 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    check_eq("drain_timeout", qsize(d), 32'd0);
  endtask

  task automatic do_op(input int d, input op_t o);
    wait_ready(d);
    drive(d, o);
    @(negedge clk);
    req[d] = 1'b0;
    drain(d);
  endtask

  function automatic op_t mk(input bit w, input bit [1:0] s, input bit u, input logic [31:0] ad,
                             input logic [31:0] dat, input logic [31:0] r, input bit e);
    op_t o;
    o.we = w; o.sz = s; o.uns = u; o.a = ad; o.wd = dat; o.rd = r; o.err = e;
    return o;
  endfunction

  op_t lat_ops[2];
  op_t b2b[6];

  initial begin
    rst_n = 1'b0;
    req = '0; we = '0; uns = '0; size = '0; a = '0; wd = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_ready", 32'(ready[d]), 32'd1);
      check_eq("rst_rvalid", 32'(rvalid[d]), 32'd0);
      check_eq("rst_rd", rd[d], 32'd0);
      check_eq("rst_err", 32'(err[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Latency and ready-low window on the LATENCY=2 instance.
    lat_ops[0] = mk(1, 2'b10, 0, 32'h40, 32'h12345678, 32'h0, 0);
    lat_ops[1] = mk(0, 2'b10, 0, 32'h40, 32'h0, 32'h12345678, 0);
    foreach (lat_ops[k]) begin
      wait_ready(0);
      drive(0, lat_ops[k]);
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        if (i == 1) req[0] = 1'b0;
        #1;
        check_eq("lat_ready", 32'(ready[0]), (i == 4) ? 32'd1 : 32'd0);
      end
      check_eq("lat_drained", q0.size(), 32'd0);
    end

    // Reset mid-WAIT aborts the store; rd holds 0x12345678 beforehand.
    wait_ready(0);
    we[0] = 1'b1; size[0] = 2'b10; a[0] = 32'h10; wd[0] = 32'hDEADBEEF; req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_eq("abort_ready", 32'(ready[0]), 32'd1);
    check_eq("abort_rvalid", 32'(rvalid[0]), 32'd0);
    check_eq("abort_rd", rd[0], 32'd0);
    check_eq("abort_err", 32'(err[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(0, mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0));

    // Byte/half lanes.
    do_op(0, mk(1, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0));
    do_op(0, mk(1, 2'b00, 0, 32'h21, 32'hFFFFFFAB, 32'h0, 0));
    do_op(0, mk(1, 2'b01, 0, 32'h22, 32'hFFFFC0DE, 32'h0, 0));
    do_op(0, mk(0, 2'b10, 0, 32'h20, 32'h0, 32'hC0DEAB00, 0));

    // Sign/zero extension.
    do_op(0, mk(1, 2'b10, 0, 32'h30, 32'h80FF7F01, 32'h0, 0));
    do_op(0, mk(0, 2'b00, 0, 32'h32, 32'h0, 32'hFFFFFFFF, 0));
    do_op(0, mk(0, 2'b00, 1, 32'h32, 32'h0, 32'h000000FF, 0));
    do_op(0, mk(0, 2'b01, 0, 32'h32, 32'h0, 32'hFFFF80FF, 0));
    do_op(0, mk(0, 2'b01, 1, 32'h30, 32'h0, 32'h00007F01, 0));

    // Error responses, then confirm nothing was written.
    do_op(0, mk(0, 2'b01, 0, 32'h31, 32'h0, 32'h0, 1));
    do_op(0, mk(1, 2'b10, 0, 32'h22, 32'hFFFFFFFF, 32'h0, 1));
    do_op(0, mk(1, 2'b11, 0, 32'h0, 32'h55555555, 32'h0, 1));
    do_op(0, mk(0, 2'b10, 0, 32'h2000, 32'h0, 32'h0, 1));
    do_op(0, mk(0, 2'b10, 0, 32'h20, 32'h0, 32'hC0DEAB00, 0));
    do_op(0, mk(0, 2'b10, 0, 32'h0, 32'h0, 32'h0, 0));

    // Back-to-back on the LATENCY=0 instance with req held high.
    b2b[0] = mk(1, 2'b10, 0, 32'h8, 32'h11223344, 32'h0, 0);
    b2b[1] = mk(0, 2'b10, 0, 32'h8, 32'h0, 32'h11223344, 0);
    b2b[2] = mk(1, 2'b01, 0, 32'hA, 32'h0000BEEF, 32'h0, 0);
    b2b[3] = mk(0, 2'b10, 0, 32'h8, 32'h0, 32'hBEEF3344, 0);
    b2b[4] = mk(0, 2'b01, 0, 32'hA, 32'h0, 32'hFFFFBEEF, 0);
    b2b[5] = mk(0, 2'b00, 1, 32'h9, 32'h0, 32'h00000033, 0);
    wait_ready(1);
    foreach (b2b[k]) begin
      check_eq("b2b_ready_hi", 32'(ready[1]), 32'd1);
      drive(1, b2b[k]);
      @(negedge clk);
      check_eq("b2b_ready_lo", 32'(ready[1]), 32'd0);
      check_eq("b2b_rvalid", 32'(rvalid[1]), 32'd1);
      @(negedge clk);
    end
    req[1] = 1'b0;
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
